// File: rtl/tdm_1to4_demux_pkg.sv
// Shared constants and types for the TDM nibble-bus receiver (and future transmitter).
package tdm_1to4_demux_pkg;

    localparam int NCH       = 4;
    localparam int CH_IDX_W  = 2;
    localparam int ERR_CNT_W = 8;

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        logic [ERR_CNT_W-1:0] r;
        if (v == {ERR_CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tdm_1to4_demux.sv
// Receive side of the 4-channel TDM nibble bus: collects ch0..ch2 in staging
// registers and publishes all four channels atomically when the ch3 word lands.
import tdm_1to4_demux_pkg::*;

module tdm_1to4_demux #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic              sof,
    output logic [DATA_W-1:0] ch0,
    output logic [DATA_W-1:0] ch1,
    output logic [DATA_W-1:0] ch2,
    output logic [DATA_W-1:0] ch3,
    output logic [3:0]        ch_valid,
    output logic              frame_done,
    output logic              sync_err,
    output logic [7:0]        err_cnt,
    output logic [1:0]        cur_ch
);

    state_t                 state_reg, state_next;
    logic [CH_IDX_W-1:0]    cur_ch_reg, cur_ch_next;
    logic [NCH-1:0]         ch_valid_reg, ch_valid_next;
    logic                   frame_done_reg, frame_done_next;
    logic                   sync_err_reg, sync_err_next;
    logic [ERR_CNT_W-1:0]   err_cnt_reg, err_cnt_next;

    // The ch3 word bypasses staging and goes straight to the output bank,
    // so only ch0..ch2 need holding registers.
    logic [DATA_W-1:0]      stage_reg [NCH-1];
    logic [NCH-2:0]         stage_we;
    logic                   publish;
    logic [DATA_W-1:0]      out_reg   [NCH];

    // Next-state, staging write enables and pulse outputs for the accepted word.
    always_comb begin
        state_next      = state_reg;
        cur_ch_next     = cur_ch_reg;
        ch_valid_next   = '0;
        frame_done_next = 1'b0;
        sync_err_next   = 1'b0;
        err_cnt_next    = err_cnt_reg;
        stage_we        = '0;
        publish         = 1'b0;
        if (din_valid) begin
            case (state_reg)
                ST_HUNT: begin
                    // Non-sof words while hunting are silently discarded.
                    if (sof) begin
                        stage_we[0]   = 1'b1;
                        ch_valid_next = 4'b0001;
                        cur_ch_next   = 2'd1;
                        state_next    = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (sof) begin
                        // sof mid-frame is a short frame; it still starts a new one.
                        if (cur_ch_reg != 2'd0) begin
                            sync_err_next = 1'b1;
                            err_cnt_next  = sat_inc(err_cnt_reg);
                        end
                        stage_we[0]   = 1'b1;
                        ch_valid_next = 4'b0001;
                        cur_ch_next   = 2'd1;
                    end else if (cur_ch_reg == 2'd0) begin
                        // Expected a frame start but got a continuation word.
                        sync_err_next = 1'b1;
                        err_cnt_next  = sat_inc(err_cnt_reg);
                        state_next    = ST_HUNT;
                    end else begin
                        ch_valid_next[cur_ch_reg] = 1'b1;
                        cur_ch_next               = cur_ch_reg + 2'd1;
                        if (cur_ch_reg == 2'd3) begin
                            publish         = 1'b1;
                            frame_done_next = 1'b1;
                        end else if (cur_ch_reg == 2'd1) begin
                            stage_we[1] = 1'b1;
                        end else begin
                            stage_we[2] = 1'b1;
                        end
                    end
                end
                default: state_next = ST_HUNT;
            endcase
        end
    end

    // FSM, channel counter, pulse outputs and error counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_HUNT;
            cur_ch_reg     <= '0;
            ch_valid_reg   <= '0;
            frame_done_reg <= 1'b0;
            sync_err_reg   <= 1'b0;
            err_cnt_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            cur_ch_reg     <= cur_ch_next;
            ch_valid_reg   <= ch_valid_next;
            frame_done_reg <= frame_done_next;
            sync_err_reg   <= sync_err_next;
            err_cnt_reg    <= err_cnt_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCH - 1; gi++) begin : g_stage
            // Staging register for channel gi; written only when that word is accepted.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    stage_reg[gi] <= '0;
                end else if (stage_we[gi]) begin
                    stage_reg[gi] <= din;
                end
            end

            // Published word for channel gi, copied from staging on frame completion.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    out_reg[gi] <= '0;
                end else if (publish) begin
                    out_reg[gi] <= stage_reg[gi];
                end
            end
        end
    endgenerate

    // Published ch3 word, taken directly from the bus on the completing edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_reg[NCH-1] <= '0;
        end else if (publish) begin
            out_reg[NCH-1] <= din;
        end
    end

    assign ch0        = out_reg[0];
    assign ch1        = out_reg[1];
    assign ch2        = out_reg[2];
    assign ch3        = out_reg[3];
    assign ch_valid   = ch_valid_reg;
    assign frame_done = frame_done_reg;
    assign sync_err   = sync_err_reg;
    assign err_cnt    = err_cnt_reg;
    assign cur_ch     = cur_ch_reg;

endmodule

// File: tb/tb_tdm_1to4_demux.sv
// Testbench for tdm_1to4_demux: reference model with a scoreboard of published frames.
module tb_tdm_1to4_demux;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] din;
    logic       din_valid;
    logic       sof;
    logic [3:0] ch0, ch1, ch2, ch3;
    logic [3:0] ch_valid;
    logic       frame_done;
    logic       sync_err;
    logic [7:0] err_cnt;
    logic [1:0] cur_ch;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic        m_run;
    int          m_cur;
    logic [3:0]  m_stage [3];
    logic [7:0]  m_err;
    logic [15:0] m_pub;
    logic [15:0] frame_q [$];
    logic [3:0]  exp_chv;
    logic        exp_fd;
    logic        exp_se;

    tdm_1to4_demux #(.DATA_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .sof        (sof),
        .ch0        (ch0),
        .ch1        (ch1),
        .ch2        (ch2),
        .ch3        (ch3),
        .ch_valid   (ch_valid),
        .frame_done (frame_done),
        .sync_err   (sync_err),
        .err_cnt    (err_cnt),
        .cur_ch     (cur_ch)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_cur  = 0;
        m_err  = 8'd0;
        m_pub  = 16'h0000;
        for (int i = 0; i < 3; i++) m_stage[i] = 4'h0;
        frame_q.delete();
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ".ch_valid"}, 32'(ch_valid), 32'(exp_chv));
        check_val({tag, ".frame_done"}, 32'(frame_done), 32'(exp_fd));
        check_val({tag, ".sync_err"}, 32'(sync_err), 32'(exp_se));
        check_val({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_err));
        check_val({tag, ".cur_ch"}, 32'(cur_ch), 32'(m_cur));
        check_val({tag, ".chs"}, 32'({ch0, ch1, ch2, ch3}), 32'(m_pub));
    endtask

    // Drive one cycle of bus stimulus, update the model, check 1 ns after the edge.
    task automatic drive(input logic v, input logic s, input logic [3:0] d, input bit quiet = 0);
        din_valid = v;
        sof       = s;
        din       = d;
        exp_chv = 4'b0000;
        exp_fd  = 1'b0;
        exp_se  = 1'b0;
        if (v) begin
            if (!m_run) begin
                if (s) begin
                    m_stage[0] = d; m_cur = 1; m_run = 1'b1; exp_chv = 4'b0001;
                end
            end else if (s) begin
                if (m_cur != 0) begin
                    exp_se = 1'b1;
                    if (m_err != 8'hFF) m_err = m_err + 8'd1;
                end
                m_stage[0] = d; m_cur = 1; exp_chv = 4'b0001;
            end else if (m_cur == 0) begin
                exp_se = 1'b1;
                if (m_err != 8'hFF) m_err = m_err + 8'd1;
                m_run = 1'b0;
            end else begin
                exp_chv = 4'b0001 << m_cur;
                if (m_cur == 3) begin
                    frame_q.push_back({m_stage[0], m_stage[1], m_stage[2], d});
                    exp_fd = 1'b1;
                    m_cur  = 0;
                end else begin
                    m_stage[m_cur] = d;
                    m_cur = m_cur + 1;
                end
            end
        end
        @(posedge clk);
        #1;
        if (exp_fd) begin
            if (frame_q.size() == 0) begin
                check_val("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                m_pub = frame_q.pop_front();
            end
        end
        check_all("cyc");
        if (!quiet)
            $display("txn v=%0b sof=%0b din=%h -> chv=%b fd=%0b se=%0b err=%0d cur=%0d ch=%h%h%h%h",
                     v, s, d, ch_valid, frame_done, sync_err, err_cnt, cur_ch, ch0, ch1, ch2, ch3);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'($urandom_range(0, 15)));
    endtask

    task automatic send_frame(input logic [15:0] f, input int gaps);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, (i == 0), f[15 - 4*i -: 4]);
            if (i < 3) gap(gaps);
        end
    endtask

    initial begin
        reset = 1'b1; din = 4'h0; din_valid = 1'b0; sof = 1'b0;
        model_reset();
        exp_chv = 4'b0; exp_fd = 1'b0; exp_se = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b0;

        // 1: back-to-back frame
        send_frame(16'h0123, 0);
        check_val("t1.frame", 32'({ch0, ch1, ch2, ch3}), 32'h0123);

        // 2: frame with 3-cycle gaps; old frame held until completion
        send_frame(16'h4567, 3);
        check_val("t2.frame", 32'({ch0, ch1, ch2, ch3}), 32'h4567);
        gap(2);

        // 3: from HUNT, non-sof words are ignored, then a good frame
        drive(1'b1, 1'b0, 4'h1);   // lost sync -> HUNT (error)
        drive(1'b1, 1'b0, 4'h2);
        drive(1'b1, 1'b0, 4'h3);
        drive(1'b1, 1'b0, 4'h4);
        check_val("t3.err_cnt", 32'(err_cnt), 32'd1);
        send_frame(16'h89AB, 0);
        check_val("t3.frame", 32'({ch0, ch1, ch2, ch3}), 32'h89AB);

        // 4: short frame followed by a full one
        drive(1'b1, 1'b1, 4'hC);
        drive(1'b1, 1'b0, 4'hD);
        send_frame(16'hF96B, 0);
        check_val("t4.frame", 32'({ch0, ch1, ch2, ch3}), 32'hF96B);
        check_val("t4.err_cnt", 32'(err_cnt), 32'd2);

        // 5: word without sof after a full frame, then saturate the counter
        drive(1'b1, 1'b0, 4'h5);
        check_val("t5.cur_ch", 32'(cur_ch), 32'd0);
        drive(1'b1, 1'b0, 4'h6);   // in HUNT: ignored, no error
        check_val("t5.hunt_noerr", 32'(sync_err), 32'd0);
        drive(1'b1, 1'b1, 4'h7);
        for (int i = 0; i < 300; i++) drive(1'b1, 1'b1, 4'($urandom_range(0, 15)), 1'b1);
        check_val("t5.err_sat", 32'(err_cnt), 32'd255);
        drive(1'b1, 1'b1, 4'h1);
        check_val("t5.err_hold", 32'(err_cnt), 32'd255);

        // 6: async reset mid-cycle after two words of a frame
        send_frame(16'h2468, 0);
        drive(1'b1, 1'b1, 4'hA);
        drive(1'b1, 1'b0, 4'hB);
        din_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        exp_chv = 4'b0; exp_fd = 1'b0; exp_se = 1'b0;
        check_all("t6.async");
        @(posedge clk);
        #1 reset = 1'b0;
        drive(1'b1, 1'b0, 4'hC);
        drive(1'b1, 1'b0, 4'hD);
        check_val("t6.ignored", 32'({ch0, ch1, ch2, ch3, ch_valid}), 32'h0);
        send_frame(16'h1357, 0);
        check_val("t6.frame", 32'({ch0, ch1, ch2, ch3}), 32'h1357);
        check_val("t6.err_cnt", 32'(err_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
